polyvec_ntt_seq: RTL and testbench
==================================

# polyvec_ntt_seq

Parametrised sequencer that runs a vector of L polynomials, one at a time, through a single shared transform core: forward NTT or inverse NTT-to-Montgomery, selected per job. It sits between the key-generation, signing and verification datapaths and one external polynomial transform core. It adds three things to the fixed-L inverse-only vector wrappers: runtime mode select, a per-polynomial skip mask and an explicit busy indication.

## Interface
- L, default 5: polynomials per vector (1..15).
- N, default 256: coefficients per polynomial.
- COEFF_W, default 32: signed coefficient width. POLY_W = N*COEFF_W (8192 at defaults).
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level request; sampled in IDLE.
- mode  in  1  0 = forward NTT, 1 = inverse NTT-to-Montgomery; latched at capture.
- en_mask  in  L  bit k=1 transforms poly k; bit k=0 passes poly k through unchanged.
- v_in  in  L*POLY_W  signed; poly k at bits [POLY_W*k +: POLY_W].
- v_out  out  L*POLY_W  signed result, same packing; registered.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- core_start  out  1  level start to transform core.
- core_mode  out  1  latched mode, stable for the whole job.
- core_inp  out  POLY_W  registered operand to the core.
- core_out  in  POLY_W  core result, valid while core_done=1.
- core_done  in  1  core completion.

## Operation
- States: IDLE, CAPTURE, SELECT, RUN, RELEASE, DONE.
- IDLE: if start=1, go to CAPTURE.
- CAPTURE: latch v_in, mode and en_mask into internal registers. Clear index. Go to SELECT. Later changes on v_in, mode or en_mask are ignored.
- SELECT, index==L: go to DONE.
- SELECT, mask[index]=0: copy the latched poly[index] to the v_out slot, increment index, stay in SELECT.
- SELECT, mask[index]=1: load core_inp with poly[index] and go to RUN.
- RUN: hold core_start=1. On core_done=1:
  - write core_out to v_out slot[index];
  - increment index;
  - go to RELEASE.
- RELEASE: core_start=0 for exactly one cycle so the core returns to idle. Then go to SELECT.
- DONE: done=1. Go to IDLE when start=0; stay in DONE while start=1.
- index width is $clog2(L+1). Index never exceeds L and never wraps.
- Only the v_out slot being written changes. Other slots hold their values until that slot is written in a later job.
- No arithmetic is performed in this block. Data is moved bit-exact, with no sign extension or truncation.

## Timing
- Reset values: v_out=0, core_inp=0, core_start=0, core_mode=0, busy=0, done=0. The latched operands are cleared and state returns to IDLE.
- Reset asserted mid-job aborts the job on the next edge. core_start drops in the same cycle the reset values apply.
- busy, done and core_start are decoded from the registered state only. They have no combinational path from start or core_done.
- start is sampled high at edge 0. CAPTURE occupies cycle 1.
- Each skipped poly costs 1 cycle.
- Each transformed poly costs 1 cycle (SELECT) + C_k (RUN cycles, including the core_done cycle) + 1 cycle (RELEASE).
- The final SELECT costs 1 cycle. done first rises at cycle 3 + S + Σ(C_k + 2), where S is the number of skipped polys.
- v_out is final in the cycle done first rises.
- If start is already low on entry to DONE, done is high for exactly 1 cycle.
- start deasserted mid-job is ignored; the job completes.
- start held high after done keeps the block in DONE. A new job needs start to go low, then high again.
- en_mask all zero means no core activity; done at cycle 3+L.
- core_done=1 outside RUN is ignored.

## Configuration
- POLYVEC_NTT_SEQ_SKIP_MASK_EN defined: en_mask behaves as above.
- Macro undefined: en_mask is ignored and every poly is transformed. The port remains present so instantiations are identical.

## Structure
- Shared package polyvec_pkg holds:
  - N, COEFF_W and POLY_W defaults;
  - the mode encodings MODE_NTT=1'b0 and MODE_INVNTT=1'b1;
  - the state encoding for this sequencer.
- Single flat module with no sub-module. The transform core is instantiated by the parent and connects through the core_* ports.

## Test plan
- L=5, mode=1, mask=5'b11111, core model with C=10 that returns input XOR poly-index pattern:
  - core_start rises 5 times;
  - core_mode=1 throughout;
  - v_out slot k equals the expected pattern;
  - done rises at cycle 3+5·12=63.
- mask=5'b00000, v_in random:
  - no core_start;
  - v_out==v_in;
  - done at cycle 8 with busy high for cycles 1–7.
- mask=5'b10100, mode=0, C=4:
  - the core sees only polys 2 and 4, with core_mode=0;
  - slots 0, 1, 3 pass through unchanged;
  - done at cycle 3+3+2·6=18.
- reset pulsed in the 3rd RUN cycle of poly 1:
  - next cycle, state is IDLE and all outputs are 0;
  - a fresh start completes a normal job.
- start held high 20 cycles past done: done stays high with no restart. start then drops: done falls on the next edge, and a re-assert launches a second job.
- Macro undefined, mask=5'b00000: all 5 polys are transformed.

Source files
------------

// File: rtl/polyvec_pkg.sv
// polyvec_pkg: shared definitions for the polynomial-vector transform blocks.
//   N_DEFAULT / COEFF_W_DEFAULT / POLY_W_DEFAULT : default polynomial geometry
//   MODE_NTT / MODE_INVNTT                       : transform-core mode encodings
//   seq_state_e                                  : polyvec_ntt_seq FSM states
package polyvec_pkg;

    localparam int N_DEFAULT       = 256;
    localparam int COEFF_W_DEFAULT = 32;
    localparam int POLY_W_DEFAULT  = N_DEFAULT * COEFF_W_DEFAULT;

    localparam logic MODE_NTT    = 1'b0;
    localparam logic MODE_INVNTT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SELECT  = 3'd2,
        ST_RUN     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/polyvec_ntt_seq.sv
// polyvec_ntt_seq: walks a vector of L polynomials through one shared
// transform core, forward NTT or inverse NTT-to-Montgomery chosen per job.
//
// Optional feature: define POLYVEC_NTT_SEQ_SKIP_MASK_EN to honour en_mask
// (bit k = 0 passes poly k through unchanged). Without it every poly is
// transformed and en_mask is ignored; the port stays for identical hookups.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   start                 level request, sampled in IDLE
//   mode                  0 = forward NTT, 1 = inverse; latched at capture
//   en_mask [L]           per-poly transform enable (see macro above)
//   v_in  [L*POLY_W]      input vector, poly k at [POLY_W*k +: POLY_W]
//   v_out [L*POLY_W]      registered result, same packing
//   busy / done           job in progress / job finished (held while start=1)
//   core_start/core_mode  level start and latched mode to the core
//   core_inp [POLY_W]     registered operand to the core
//   core_out, core_done   core result, valid while core_done=1
//
// Core handshake: core_start is a level held through RUN; the core raises
// core_done for the cycle its result is valid on core_out. core_start then
// drops for exactly one RELEASE cycle so the core returns to idle before the
// next operand. core_done seen in any other state is ignored.
module polyvec_ntt_seq
    import polyvec_pkg::*;
#(
    parameter int  L       = 5,
    parameter int  N       = N_DEFAULT,
    parameter int  COEFF_W = COEFF_W_DEFAULT,
    localparam int POLY_W  = N * COEFF_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [L-1:0]        en_mask,
    input  logic [L*POLY_W-1:0] v_in,
    output logic [L*POLY_W-1:0] v_out,
    output logic                busy,
    output logic                done,
    output logic                core_start,
    output logic                core_mode,
    output logic [POLY_W-1:0]   core_inp,
    input  logic [POLY_W-1:0]   core_out,
    input  logic                core_done
);

    localparam int IDX_W = $clog2(L + 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [POLY_W-1:0] poly_q [L];
    logic [POLY_W-1:0] out_q  [L];
    logic [L-1:0]      mask_q;
    logic              mode_q;
    logic [POLY_W-1:0] inp_q;
    logic              at_end;
    logic              sel_en;

    assign at_end = (idx_q == IDX_W'(L));
    assign sel_en = mask_q[idx_q];

    // Next state and state-decoded outputs; nothing here depends on start
    // or core_done for the outputs, only for the next state.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        core_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                busy    = 1'b1;
                state_d = ST_SELECT;
            end
            ST_SELECT: begin
                busy = 1'b1;
                if (at_end)      state_d = ST_DONE;
                else if (sel_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy       = 1'b1;
                core_start = 1'b1;
                if (core_done) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                busy    = 1'b1;
                state_d = ST_SELECT;
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            mode_q  <= 1'b0;
            inp_q   <= '0;
            for (int k = 0; k < L; k++) begin
                poly_q[k] <= '0;
                out_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_CAPTURE: begin
                    for (int k = 0; k < L; k++) begin
                        poly_q[k] <= v_in[POLY_W*k +: POLY_W];
                    end
                    mode_q <= mode;
`ifdef POLYVEC_NTT_SEQ_SKIP_MASK_EN
                    mask_q <= en_mask;
`else
                    // Mask forced to all ones: every poly goes through the core.
                    mask_q <= en_mask | {L{1'b1}};
`endif
                    idx_q  <= '0;
                end
                ST_SELECT: begin
                    // idx_q < L is guaranteed whenever at_end is low.
                    if (!at_end) begin
                        if (sel_en) begin
                            inp_q <= poly_q[idx_q];
                        end else begin
                            out_q[idx_q] <= poly_q[idx_q];
                            idx_q        <= idx_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        out_q[idx_q] <= core_out;
                        idx_q        <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_mode = mode_q;
    assign core_inp  = inp_q;

    for (genvar k = 0; k < L; k++) begin : g_vout
        assign v_out[POLY_W*k +: POLY_W] = out_q[k];
    end

endmodule

// File: tb/tb_polyvec_ntt_seq.sv
// tb_polyvec_ntt_seq: directed scoreboard bench for polyvec_ntt_seq.
// A behavioural core model answers core_start after a per-job latency with
// core_inp XOR a per-poly pattern; the driver pushes expected results when it
// issues each job and a monitor pops and compares when done rises.
`timescale 1ns/1ps
module tb_polyvec_ntt_seq;
    import polyvec_pkg::*;

    localparam int L       = 5;
    localparam int N       = 256;
    localparam int COEFF_W = 32;
    localparam int POLY_W  = N * COEFF_W;
    localparam int VW      = L * POLY_W;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              mode  = 1'b0;
    logic [L-1:0]      en_mask = '0;
    logic [VW-1:0]     v_in = '0;
    logic [VW-1:0]     v_out;
    logic              busy, done, core_start, core_mode;
    logic [POLY_W-1:0] core_inp;
    logic [POLY_W-1:0] core_out = '0;
    logic              core_done = 1'b0;

    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   cyc       = 0;
    int   core_lat  = 2;
    logic job_mode  = 1'b0;
    logic core_force = 1'b0;

    // scoreboard queues
    logic [VW-1:0]     exp_vout_q[$];
    int                exp_cyc_q[$];
    int                exp_len_q[$];
    int                exp_ncore_q[$];
    int                exp_idx_q[$];
    logic [POLY_W-1:0] exp_op_q[$];

    polyvec_ntt_seq #(.L(L), .N(N), .COEFF_W(COEFF_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .en_mask    (en_mask),
        .v_in       (v_in),
        .v_out      (v_out),
        .busy       (busy),
        .done       (done),
        .core_start (core_start),
        .core_mode  (core_mode),
        .core_inp   (core_inp),
        .core_out   (core_out),
        .core_done  (core_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;
    always @(posedge clock) cyc = cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic check_wide(input string name, input logic [POLY_W-1:0] act,
                              input logic [POLY_W-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got ..%h, expected ..%h (low 64 bits, cyc %0d)",
                      name, act[63:0], exp[63:0], cyc);
    endtask

    function automatic logic [POLY_W-1:0] pat(input int k);
        logic [POLY_W-1:0] p;
        for (int j = 0; j < N; j++)
            p[32*j +: 32] = 32'hF0F0_0000 ^ 32'((k + 1) * 32'h0001_0001) ^ 32'(j);
        return p;
    endfunction

    function automatic logic [VW-1:0] make_vec(input int seed);
        logic [VW-1:0] v;
        for (int k = 0; k < L; k++)
            for (int j = 0; j < N; j++)
                v[POLY_W*k + 32*j +: 32] = {1'(j & 1), 7'(k), 8'(seed), 16'(j)};
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW/32; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [L-1:0] eff_mask(input logic [L-1:0] m);
`ifdef POLYVEC_NTT_SEQ_SKIP_MASK_EN
        return m;
`else
        return m | {L{1'b1}};
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Issues one job; leaves the bench in cycle 2 of the job (first SELECT).
    task automatic launch(input logic m, input logic [L-1:0] msk, input logic [VW-1:0] vin,
                          input int lat, input int exp_len, input bit track, input bit hold);
        logic [L-1:0]  eff;
        logic [VW-1:0] ev;
        int            nc;
        eff = eff_mask(msk);
        nc  = 0;
        core_lat = lat;
        job_mode = m;
        for (int k = 0; k < L; k++) begin
            if (eff[k]) begin
                exp_idx_q.push_back(k);
                exp_op_q.push_back(vin[POLY_W*k +: POLY_W]);
                ev[POLY_W*k +: POLY_W] = vin[POLY_W*k +: POLY_W] ^ pat(k);
                nc++;
            end else begin
                ev[POLY_W*k +: POLY_W] = vin[POLY_W*k +: POLY_W];
            end
        end
        tick();
        start   = 1'b1;
        mode    = m;
        en_mask = msk;
        v_in    = vin;
        if (track) begin
            exp_cyc_q.push_back(cyc + exp_len);
            exp_len_q.push_back(exp_len);
            exp_vout_q.push_back(ev);
            exp_ncore_q.push_back(nc);
        end
        tick();   // cycle 1: CAPTURE
        check("busy_capture", busy, 1);
        check("done_capture", done, 0);
        if (!hold) start = 1'b0;
        tick();   // cycle 2: operands already latched, scramble inputs
        v_in    = ~vin;
        mode    = ~m;
        en_mask = ~msk;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_within_budget", done, 1);
    endtask

    // ---------------- core model ----------------
    initial begin
        int   cnt;
        int   cur;
        logic prev_cs;
        logic [POLY_W-1:0] op;
        cnt = 0; cur = 0; prev_cs = 1'b0;
        forever begin
            tick();
            if (core_force) begin
                core_done = 1'b1;
                core_out  = {POLY_W{1'b1}};
            end else if (core_start) begin
                if (!prev_cs) begin
                    cnt = 0;
                    if (exp_idx_q.size() == 0) begin
                        check("core_start_expected", 0, 1);
                    end else begin
                        cur = exp_idx_q.pop_front();
                        op  = exp_op_q.pop_front();
                        check_wide($sformatf("core_inp_poly%0d", cur), core_inp, op);
                        check("core_mode", core_mode, job_mode);
                    end
                end
                cnt++;
                core_done = (cnt == core_lat);
                core_out  = core_inp ^ pat(cur);
            end else begin
                cnt       = 0;
                core_done = 1'b0;
                core_out  = '0;
            end
            prev_cs = core_start;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev_done, prev_cs;
        int   busy_cnt, ncore;
        int   ecyc, elen, enc;
        logic [VW-1:0] ev;
        prev_done = 1'b0; prev_cs = 1'b0; busy_cnt = 0; ncore = 0;
        forever begin
            tick();
            if (reset) begin
                busy_cnt = 0;
                ncore    = 0;
            end else begin
                if (busy) busy_cnt++;
                if (core_start && !prev_cs) ncore++;
                if (done && !prev_done) begin
                    if (exp_cyc_q.size() == 0) begin
                        check("done_expected", 0, 1);
                    end else begin
                        ecyc = exp_cyc_q.pop_front();
                        elen = exp_len_q.pop_front();
                        ev   = exp_vout_q.pop_front();
                        enc  = exp_ncore_q.pop_front();
                        check("done_cycle", cyc, ecyc);
                        for (int k = 0; k < L; k++)
                            check_wide($sformatf("v_out_slot%0d", k),
                                       v_out[POLY_W*k +: POLY_W], ev[POLY_W*k +: POLY_W]);
                        check("core_start_count", ncore, enc);
                        check("busy_cycles", busy_cnt, elen - 1);
                        check("busy_low_in_done", busy, 0);
                    end
                    busy_cnt = 0;
                    ncore    = 0;
                end
            end
            prev_done = done;
            prev_cs   = core_start;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_mode", core_mode, 0);
        check_wide("rst_core_inp", core_inp, '0);
        for (int k = 0; k < L; k++)
            check_wide($sformatf("rst_v_out_slot%0d", k), v_out[POLY_W*k +: POLY_W], '0);
        reset = 1'b0;
        tick();

        // Job 1: inverse, all enabled, C=10 -> done at 3 + 5*12 = 63
        launch(MODE_INVNTT, 5'b11111, make_vec(1), 10, 63, 1'b1, 1'b0);
        wait_done(200);
        tick();
        check("done_one_cycle_j1", done, 0);

        // Job 2: mask 0, random data, C=3
`ifdef POLYVEC_NTT_SEQ_SKIP_MASK_EN
        launch(MODE_INVNTT, 5'b00000, rand_vec(), 3, 8, 1'b1, 1'b0);
`else
        launch(MODE_INVNTT, 5'b00000, rand_vec(), 3, 28, 1'b1, 1'b0);
`endif
        wait_done(200);
        tick();
        check("done_one_cycle_j2", done, 0);

        // Job 3: forward, mask 10100, C=4
`ifdef POLYVEC_NTT_SEQ_SKIP_MASK_EN
        launch(MODE_NTT, 5'b10100, make_vec(3), 4, 18, 1'b1, 1'b0);
`else
        launch(MODE_NTT, 5'b10100, make_vec(3), 4, 33, 1'b1, 1'b0);
`endif
        wait_done(200);
        tick();

        // Job 4: reset during 3rd RUN cycle of poly 1 (cycle 17)
        launch(MODE_INVNTT, 5'b11111, make_vec(4), 10, 0, 1'b0, 1'b0);
        repeat (15) tick();
        check("core_start_before_reset", core_start, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_core_start", core_start, 0);
        check("abort_core_mode", core_mode, 0);
        check_wide("abort_core_inp", core_inp, '0);
        for (int k = 0; k < L; k++)
            check_wide($sformatf("abort_v_out_slot%0d", k), v_out[POLY_W*k +: POLY_W], '0);
        exp_idx_q.delete();
        exp_op_q.delete();

        // core_done while idle is ignored
        core_force = 1'b1;
        repeat (2) tick();
        core_force = 1'b0;
        tick();
        check("idle_core_done_busy", busy, 0);
        check_wide("idle_core_done_slot0", v_out[POLY_W-1:0], '0);

        // Fresh job after abort: forward, all enabled, C=3 -> 3 + 5*5 = 28
        launch(MODE_NTT, 5'b11111, make_vec(5), 3, 28, 1'b1, 1'b0);
        wait_done(200);
        tick();

        // Job 6: start held past done
`ifdef POLYVEC_NTT_SEQ_SKIP_MASK_EN
        launch(MODE_NTT, 5'b01010, make_vec(6), 2, 14, 1'b1, 1'b1);
`else
        launch(MODE_NTT, 5'b01010, make_vec(6), 2, 23, 1'b1, 1'b1);
`endif
        wait_done(200);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("done_held", done, 1);
            check("no_restart_core_start", core_start, 0);
        end
        start = 1'b0;
        tick();
        check("done_falls_after_release", done, 0);

        // Job 7: re-assert launches a second job, C=5 -> 3 + 5*7 = 38
        launch(MODE_INVNTT, 5'b11111, make_vec(7), 5, 38, 1'b1, 1'b0);
        wait_done(200);
        tick();
        check("done_one_cycle_j7", done, 0);

        repeat (3) tick();
        check("pending_done_jobs", exp_cyc_q.size(), 0);
        check("pending_core_ops", exp_idx_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
